// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand bundle for seq_magnitude_comparator.
// master drives start/A/B(/sgn); slave returns busy/done/G/E/L.
// sgn exists only when COMPARATOR_SIGNED_EN is defined.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef COMPARATOR_SIGNED_EN
    logic             sgn;
`endif
    logic             busy;
    logic             done;
    logic             G;
    logic             E;
    logic             L;

`ifdef COMPARATOR_SIGNED_EN
    modport master (
        output start, A, B, sgn,
        input  busy, done, G, E, L
    );
    modport slave (
        input  start, A, B, sgn,
        output busy, done, G, E, L
    );
`else
    modport master (
        output start, A, B,
        input  busy, done, G, E, L
    );
    modport slave (
        input  start, A, B,
        output busy, done, G, E, L
    );
`endif
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   start/A/B[/sgn] in; busy, done, G, E, L out (all registered).
// Optional macro COMPARATOR_SIGNED_EN adds two's-complement mode (sgn).
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                     clk,
    input logic                     rst,
    seq_magnitude_comparator_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             g_q;
    logic             e_q;
    logic             l_q;

    logic [WIDTH-1:0] flip;
    logic [DIGIT-1:0] a_top;
    logic [DIGIT-1:0] b_top;

    // Inverting the sign bit of both operands maps two's-complement
    // order onto unsigned order, so the slice datapath stays unsigned.
    always_comb begin
        flip = '0;
`ifdef COMPARATOR_SIGNED_EN
        flip[WIDTH-1] = bus.sgn;
`endif
    end

    // Operands are shifted left each step, so the slice under
    // comparison is always the top DIGIT bits.
    assign a_top = a_q[WIDTH-1 -: DIGIT];
    assign b_top = b_q[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            g_q   <= 1'b0;
            e_q   <= 1'b0;
            l_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_q   <= bus.A ^ flip;
                        b_q   <= bus.B ^ flip;
                        idx   <= LAST;
                        state <= S_CMP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CMP: begin
                    if (a_top != b_top) begin
                        g_q   <= a_top > b_top;
                        l_q   <= a_top < b_top;
                        e_q   <= 1'b0;
                        state <= S_DONE;
                    end else if (idx == '0) begin
                        g_q   <= 1'b0;
                        e_q   <= 1'b1;
                        l_q   <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        a_q <= a_q << DIGIT;
                        b_q <= b_q << DIGIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == S_CMP);
    assign bus.done = (state == S_DONE);
    assign bus.G    = g_q;
    assign bus.E    = e_q;
    assign bus.L    = l_q;
endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Multi-cycle, parametrised magnitude comparator and the successor to our combinational 4-bit comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, starting from the MSB, and stops early at the first differing slice. A start/done handshake wraps the comparison so it can sit behind a register-file or ALU sequencer without widening the critical path as WIDTH grows.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge only while busy=0.
- A  input  WIDTH  operand A; captured on the accepted start edge.
- B  input  WIDTH  operand B; captured on the accepted start edge.
- sgn  input  1  signed mode, two's complement. Present only with COMPARATOR_SIGNED_EN and captured with A and B.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when G/E/L carry a new result.
- G  output  1  A > B (registered).
- E  output  1  A == B (registered).
- L  output  1  A < B (registered).

## Operation
- N = WIDTH/DIGIT slices; slice k = bits [k*DIGIT+DIGIT-1 : k*DIGIT]. Slice N-1 is compared first.
- States:
  - IDLE: busy=0. On start=1, capture A and B into internal registers, set the slice index to N-1 and go to CMP.
  - CMP: busy=1. Each cycle, compare the indexed slices of the captured operands as unsigned values.
    - If the slices differ, write G/L from that slice, E=0, and go to DONE.
    - If they are equal and the index is 0, write E=1, G=0, L=0, and go to DONE.
    - Otherwise decrement the index and stay in CMP.
  - DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. A start seen in DONE is accepted exactly as in IDLE, going directly to CMP.
- Exactly one of G/E/L is high after any completed comparison. G/E/L hold their value until the next completion; they do not change during CMP.
- start while busy=1 is ignored and not queued. A and B changing after capture have no effect.
- Reset values: state=IDLE, busy=0, done=0, G=0, E=0, L=0. All-zero G/E/L means no valid result yet.
- rst asserted mid-comparison aborts the comparison immediately. No done pulse is produced and outputs take their reset values.

## Timing
- The start edge is t0. busy rises after t0.
- The slice comparison at edge t(j) covers slice N-j, for j = 1..N.
- The result is registered at edge t(m), where m = 1 + (N-1 − index of the first differing slice), or m = N if the operands are equal.
- done is high between t(m) and t(m+1). Latency is 1..N cycles; the worst case is N cycles (equal operands).
- The earliest next start is sampled at t(m+1), so back-to-back throughput is one comparison per m+1 cycles.
- No combinational path exists from any input to any output.

## Configuration
- COMPARATOR_SIGNED_EN defined:
  - The sgn port exists.
  - If sgn=1 at capture, bit WIDTH-1 of both captured operands is inverted before comparison, which gives a correct two's-complement ordering. Latency is unchanged.
  - If sgn=0 at capture, the comparison is unsigned.
- COMPARATOR_SIGNED_EN undefined: the sgn port is absent and all comparisons are unsigned. The logic is otherwise identical.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 (N=4).
1. A=0x1234, B=0x1234, start pulse → done 4 cycles after the start edge with E=1, G=0, L=0; busy high for exactly those 4 cycles.
2. A=0x8000, B=0x7FFF, unsigned → done 1 cycle after start with G=1, E=0, L=0.
3. Macro defined, sgn=1, A=0x8000, B=0x7FFF → done after 1 cycle with L=1. A=0xFFFF, B=0xFFFE, sgn=1 → G=1, done after 4 cycles.
4. Start accepted for A=0x00F0, B=0x00E0; a second start is pulsed one cycle later with different operands → it is ignored, and the single done pulse arrives 3 cycles after the first start with G=1.
5. Start with A=0x0001, B=0x0002, then rst high during CMP → busy, done, G, E and L drop to 0 asynchronously. No done pulse occurs after rst is released.
6. Start A=0x5000, B=0x4000; hold start=1 with new operands A=0x0003, B=0x0004 during the DONE cycle → first done with G=1; the second start is accepted at the DONE edge, and the second done follows 4 cycles later with L=1.
